// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared constants, forward-select encodings and fetch FSM type
//             for the branch/PC unit.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_nop_word = 32'h0000_0000;

    localparam logic [1:0] c_fwd_reg     = 2'b00;
    localparam logic [1:0] c_fwd_mem     = 2'b01;
    localparam logic [1:0] c_fwd_wb      = 2'b10;
    localparam logic [1:0] c_fwd_reg_alt = 2'b11;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_t;

    // Operand source selection shared by both branch comparator inputs.
    function automatic logic [31:0] fwd_select(
        input logic [1:0]  sel,
        input logic [31:0] rd,
        input logic [31:0] mem,
        input logic [31:0] wb
    );
        case (sel)
            c_fwd_mem: return mem;
            c_fwd_wb:  return wb;
            default:   return rd;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : branch_cmp
//  Brief    : ID-stage operand forwarding, taken decision and target address.
//  Revision : 1.0  initial release
// ============================================================================
module branch_cmp
    import cpu_pkg::*;
(
    input  logic        J,
    input  logic        JR,
    input  logic        BNE,
    input  logic        BGTZ,
    input  logic [1:0]  DA,
    input  logic [1:0]  DB,
    input  logic [31:0] rd_a,
    input  logic [31:0] rd_b,
    input  logic [31:0] fwd_mem,
    input  logic [31:0] fwd_wb,
    input  logic [31:0] instr_id,
    input  logic [31:0] pc4_id,
    input  logic        valid_id,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_br_off;
    logic        w_cond;
    logic        w_unused_opcode;

    assign w_op_a   = fwd_select(DA, rd_a, fwd_mem, fwd_wb);
    assign w_op_b   = fwd_select(DB, rd_b, fwd_mem, fwd_wb);
    assign w_br_off = {{14{instr_id[15]}}, instr_id[15:0], 2'b00};

    // Opcode bits are decoded upstream; only the immediate fields matter here.
    assign w_unused_opcode = ^instr_id[31:26];

    always_comb begin
        w_cond = 1'b0;
        if (J) begin
            w_cond = 1'b1;
        end else if (BNE) begin
            w_cond = (w_op_a != w_op_b);
        end else if (BGTZ) begin
            w_cond = ($signed(w_op_a) > 32'sd0);
        end
    end

    assign taken = valid_id & w_cond;

    always_comb begin
        target = pc4_id + w_br_off;
        if (J && !JR) begin
            target = {pc4_id[31:28], instr_id[25:0], 2'b00};
        end else if (J && JR) begin
            target = {w_op_a[31:2], 2'b00};
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pc_unit
//  Brief    : Fetch PC register, IF/ID pipeline register and redirect control
//             with a one-bubble flush after every taken transfer.
//  Revision : 1.0  initial release
// ============================================================================
module branch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        J,
    input  logic        JR,
    input  logic        BNE,
    input  logic        BGTZ,
    input  logic [1:0]  DA,
    input  logic [1:0]  DB,
    input  logic [31:0] rd_a,
    input  logic [31:0] rd_b,
    input  logic [31:0] fwd_mem,
    input  logic [31:0] fwd_wb,
    input  logic        stall_id,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_if,
    output logic [31:0] instr_id,
    output logic [31:0] pc4_id,
    output logic        valid_id,
    output logic        redirect
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  r_pc4;
    logic         r_valid;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_instr_nxt;
    logic [31:0]  w_pc4_nxt;
    logic         w_valid_nxt;
    logic [31:0]  w_pc_inc;
    logic [31:0]  w_target;
    logic         w_taken;

    branch_cmp u_branch_cmp (
        .J        (J),
        .JR       (JR),
        .BNE      (BNE),
        .BGTZ     (BGTZ),
        .DA       (DA),
        .DB       (DB),
        .rd_a     (rd_a),
        .rd_b     (rd_b),
        .fwd_mem  (fwd_mem),
        .fwd_wb   (fwd_wb),
        .instr_id (r_instr),
        .pc4_id   (r_pc4),
        .valid_id (r_valid),
        .taken    (w_taken),
        .target   (w_target)
    );

    assign w_pc_inc = r_pc + 32'd4;
    assign redirect = w_taken & ~stall_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_instr <= c_nop_word;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pc4   <= w_pc4_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // A stall freezes everything, including a pending taken transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;
        if (!stall_id) begin
            if (redirect) begin
                w_pc_nxt    = w_target;
                w_instr_nxt = c_nop_word;
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_FLUSH;
            end else if (r_state == ST_FLUSH) begin
                // The fetch issued alongside the redirect is dropped.
                w_instr_nxt = c_nop_word;
                w_valid_nxt = 1'b0;
                if (imem_ready) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_RUN;
                end
            end else if (imem_ready) begin
                w_pc_nxt    = w_pc_inc;
                w_instr_nxt = imem_rdata;
                w_pc4_nxt   = w_pc_inc;
                w_valid_nxt = 1'b1;
            end else begin
                w_instr_nxt = c_nop_word;
                w_valid_nxt = 1'b0;
            end
        end
    end

    assign pc_if    = r_pc;
    assign instr_id = r_instr;
    assign pc4_id   = r_pc4;
    assign valid_id = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_pc_unit
//  Brief    : Self-checking bench with a behavioural fetch/branch model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_pc_unit;

    localparam logic [31:0] c_rst_pc = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        J, JR, BNE, BGTZ;
    logic [1:0]  DA, DB;
    logic [31:0] rd_a, rd_b, fwd_mem, fwd_wb;
    logic        stall_id;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_if, instr_id, pc4_id;
    logic        valid_id;
    logic        redirect;

    int checks   = 0;
    int failures = 0;

    branch_pc_unit #(.RESET_PC(c_rst_pc)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .J          (J),
        .JR         (JR),
        .BNE        (BNE),
        .BGTZ       (BGTZ),
        .DA         (DA),
        .DB         (DB),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .fwd_mem    (fwd_mem),
        .fwd_wb     (fwd_wb),
        .stall_id   (stall_id),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc_if      (pc_if),
        .instr_id   (instr_id),
        .pc4_id     (pc4_id),
        .valid_id   (valid_id),
        .redirect   (redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_flush;

    function automatic logic [31:0] opnd(input logic [1:0] s, input logic [31:0] rd);
        if (s == 2'd1) return fwd_mem;
        if (s == 2'd2) return fwd_wb;
        return rd;
    endfunction

    function automatic logic m_taken();
        if (!m_valid) return 1'b0;
        if (J) return 1'b1;
        if (BNE) return opnd(DA, rd_a) != opnd(DB, rd_b);
        if (BGTZ) return $signed(opnd(DA, rd_a)) > 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_target();
        logic signed [31:0] off;
        off = $signed(m_instr[15:0]);
        if (J && !JR) return {m_pc4[31:28], m_instr[25:0], 2'b00};
        if (J) return opnd(DA, rd_a) & 32'hFFFF_FFFC;
        return m_pc4 + 32'(off * 4);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= c_rst_pc; m_instr <= 32'd0; m_pc4 <= 32'd0;
            m_valid <= 1'b0; m_flush <= 1'b0;
        end else if (!stall_id) begin
            if (m_taken()) begin
                m_pc <= m_target(); m_instr <= 32'd0; m_valid <= 1'b0; m_flush <= 1'b1;
            end else begin
                m_valid <= imem_ready && !m_flush;
                m_instr <= (imem_ready && !m_flush) ? imem_rdata : 32'd0;
                if (imem_ready) begin
                    m_pc    <= m_pc + 32'd4;
                    m_flush <= 1'b0;
                    if (!m_flush) m_pc4 <= m_pc + 32'd4;
                end
            end
        end
    end

    // Every cycle, well after the inputs settle and away from the rising edge.
    always @(negedge clk) begin
        #3;
        chk("pc_if", pc_if, m_pc);
        chk("valid_id", {31'd0, valid_id}, {31'd0, m_valid});
        chk("instr_id", instr_id, m_instr);
        if (m_valid) chk("pc4_id", pc4_id, m_pc4);
        chk("redirect", {31'd0, redirect}, {31'd0, m_taken() && !stall_id});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        J = 0; JR = 0; BNE = 0; BGTZ = 0; DA = 2'd0; DB = 2'd0; stall_id = 0;
    endtask

    task automatic fetch_valid(input logic [31:0] w);
        for (int k = 0; k < 6; k++) begin
            tick();
            idle();
            imem_ready = 1; imem_rdata = w;
            @(posedge clk);
            #1;
            if (m_valid) break;
        end
        checks++;
        if (!m_valid) begin
            failures++;
            $display("FAIL fetch_timeout: got valid 0 expected valid 1 at %0t", $time);
        end
    endtask

    initial begin
        rst_n = 0; idle();
        rd_a = 0; rd_b = 0; fwd_mem = 0; fwd_wb = 0;
        imem_ready = 0; imem_rdata = 0;
        #2;
        chk("rst_pc", pc_if, c_rst_pc);
        chk("rst_valid", {31'd0, valid_id}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        tick(); tick();

        // Sequential fetch from reset
        rst_n = 1; imem_ready = 1; imem_rdata = 32'h1111_0000;
        #2; chk("seq_pc0", pc_if, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            imem_rdata = (i == 3) ? 32'h1400_FFFE : 32'h1111_0000 + i;
            #2;
            chk("seq_pc", pc_if, 32'(4 * i));
            chk("seq_valid", {31'd0, valid_id}, 32'd1);
        end

        // bne backwards, forwarded A
        tick();
        BNE = 1; DA = 2'b01; DB = 2'b00; fwd_mem = 5; rd_b = 7;
        #2;
        chk("bne_pc4", pc4_id, 32'h10);
        chk("bne_redirect", {31'd0, redirect}, 32'd1);
        tick(); idle();
        #2;
        chk("bne_target", pc_if, 32'h08);
        chk("bne_bubble", {31'd0, valid_id}, 32'd0);
        tick();
        #2; chk("bne_flush_bubble", {31'd0, valid_id}, 32'd0);

        // bgtz: negative then positive
        fetch_valid(32'h1C20_0003);
        tick();
        BGTZ = 1; DA = 2'b00; rd_a = 32'h8000_0000; imem_ready = 1; imem_rdata = 32'h1C20_0005;
        #2; chk("bgtz_neg", {31'd0, redirect}, 32'd0);
        tick();
        BGTZ = 1; rd_a = 32'd1;
        #2; chk("bgtz_pos", {31'd0, redirect}, 32'd1);

        // jr with MEM/WB forward, low bits forced clear
        fetch_valid(32'h0000_0008);
        tick();
        J = 1; JR = 1; DA = 2'b10; fwd_wb = 32'h0000_0043; imem_ready = 0;
        #2; chk("jr_redirect", {31'd0, redirect}, 32'd1);
        tick(); idle();
        #2; chk("jr_target", pc_if, 32'h40);

        // jr to just below 0x1000_0000, then j within that region
        fetch_valid(32'h0000_0008);
        tick();
        J = 1; JR = 1; DA = 2'b10; fwd_wb = 32'h0FFF_FFFF;
        #2; chk("jr2_redirect", {31'd0, redirect}, 32'd1);
        fetch_valid(32'h0800_0100);
        #1; chk("j_pc4", pc4_id, 32'h1000_0004);
        tick();
        J = 1; JR = 0;
        #2; chk("j_redirect", {31'd0, redirect}, 32'd1);
        tick(); idle();
        #2; chk("j_target", pc_if, 32'h1000_0400);

        // Taken bne under stall
        fetch_valid(32'h1400_0010);
        tick();
        BNE = 1; DA = 0; DB = 0; rd_a = 1; rd_b = 2; stall_id = 1;
        imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
        #2;
        chk("stall_redirect", {31'd0, redirect}, 32'd0);
        chk("stall_instr", instr_id, 32'h1400_0010);
        tick();
        #2;
        chk("stall_hold_instr", instr_id, 32'h1400_0010);
        chk("stall_hold_valid", {31'd0, valid_id}, 32'd1);
        chk("stall_hold_redirect", {31'd0, redirect}, 32'd0);
        tick();
        stall_id = 0;
        #2; chk("stall_release", {31'd0, redirect}, 32'd1);

        // Asynchronous reset mid-FLUSH
        tick(); idle(); imem_ready = 0;
        #1; rst_n = 0;
        #1;
        chk("arst_pc", pc_if, c_rst_pc);
        chk("arst_valid", {31'd0, valid_id}, 32'd0);
        chk("arst_redirect", {31'd0, redirect}, 32'd0);
        tick();
        tick();
        rst_n = 1; imem_ready = 1; imem_rdata = 32'hABCD_0001;
        #2; chk("resume_pc0", pc_if, c_rst_pc);
        tick(); imem_ready = 0;
        #2;
        chk("resume_pc", pc_if, c_rst_pc + 32'd4);
        chk("resume_pc4", pc4_id, c_rst_pc + 32'd4);
        chk("resume_instr", instr_id, 32'hABCD_0001);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            int kind;
            tick();
            idle();
            rst_n      = ($urandom_range(0, 99) != 0);
            kind       = $urandom_range(0, 9);
            J          = (kind <= 1);
            JR         = (kind == 1);
            BNE        = (kind == 2);
            BGTZ       = (kind == 3);
            DA         = 2'($urandom_range(0, 3));
            DB         = 2'($urandom_range(0, 3));
            rd_a       = $urandom;
            rd_b       = ($urandom_range(0, 2) == 0) ? rd_a : $urandom;
            fwd_mem    = ($urandom_range(0, 3) == 0) ? rd_a : $urandom;
            fwd_wb     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            stall_id   = ($urandom_range(0, 4) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            imem_rdata = $urandom;
        end
        tick(); idle(); rst_n = 1;
        tick();
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 SHALL take parameter RESET_PC, default 32'h0000_0000, as the PC value loaded on reset.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising-edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: J, JR, BNE, BGTZ  in  1 each  ID-stage decode controls; J=1,JR=1 means jr.
REQ-005 SHALL have ports: DA, DB  in  2 each  operand forward selects (00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 regfile).
REQ-006 SHALL have ports: rd_a, rd_b  in  32 each  regfile read data for Rs, Rt.
REQ-007 SHALL have ports: fwd_mem, fwd_wb  in  32 each  EX/MEM and MEM/WB result buses.
REQ-008 SHALL have ports: stall_id  in  1  hold PC and IF/ID from the hazard unit.
REQ-009 SHALL have ports: imem_rdata  in  32; imem_ready  in  1  fetch data valid this cycle.
REQ-010 SHALL have ports: pc_if  out  32  fetch address; instr_id, pc4_id  out  32 each  IF/ID contents; valid_id  out  1; redirect  out  1  taken control transfer this cycle.

Function
REQ-011 SHALL form operand A from DA/rd_a/fwd_mem/fwd_wb and operand B from DB/rd_b/fwd_mem/fwd_wb, combinationally.
REQ-012 SHALL compute taken: J=1 -> taken; J=0 with BNE -> A!=B; J=0 with BGTZ -> A signed >0; otherwise not taken; the result is gated by valid_id.
REQ-013 SHALL compute target: J&!JR -> {pc4_id[31:28], instr_id[25:0], 2'b00}; J&JR -> A; branch -> pc4_id + (sign-extended instr_id[15:0] << 2), wrapping mod 2^32.
REQ-014 SHALL drive redirect = taken & !stall_id, combinationally.
REQ-015 SHALL keep a two-state fetch FSM: RUN (normal) and FLUSH (the cycle after a redirect, with the in-flight fetch discarded).
REQ-016 SHALL, when stall_id=1, hold pc_if, instr_id, pc4_id, valid_id and the FSM state unchanged, and ignore imem_ready and taken.
REQ-017 SHALL, on redirect, load pc_if <= target, clear IF/ID (instr_id=0 NOP, valid_id=0) and enter FLUSH, irrespective of imem_ready.
REQ-018 SHALL, in RUN without stall or redirect and with imem_ready=1, load pc_if <= pc_if+4, instr_id <= imem_rdata, pc4_id <= pc_if+4 and valid_id <= 1.
REQ-019 SHALL, in RUN without stall or redirect and with imem_ready=0, hold pc_if and insert a bubble (valid_id <= 0, instr_id <= 0).
REQ-020 SHALL, in FLUSH, insert a bubble, advance pc_if by 4 only if imem_ready=1, and return to RUN on that same imem_ready cycle.
REQ-021 SHALL have no delay slot: one bubble follows each taken transfer.
REQ-022 SHALL keep pc_if word-aligned; jr targets have bits [1:0] forced to 0.

Reset
REQ-023 SHALL, on rst_n low, immediately set pc_if=RESET_PC, instr_id=0, pc4_id=0, valid_id=0 and state=RUN, including mid-stall or mid-FLUSH.
REQ-024 SHALL hold redirect at 0 while in reset, since valid_id=0.
REQ-025 SHALL resume fetching from RESET_PC on the first rising edge after rst_n deasserts.

Structure
REQ-026 SHALL take RESET_PC default, the NOP word, the forward-select encodings and the FSM state type from a shared package, cpu_pkg.
REQ-027 SHALL instantiate one sub-module, branch_cmp, which is combinational and holds the operand muxes, taken logic and target computation (REQ-011 to REQ-013).

Verification
REQ-028 SHALL verify: reset, then imem_ready=1 for 3 cycles -> pc_if 0,4,8,C; valid_id=1 from the 2nd cycle.
REQ-029 SHALL verify: bne at pc4_id=0x10, imm=0xFFFE, DA=01 fwd_mem=5, rd_b=7 -> redirect=1, pc_if=0x08, one bubble.
REQ-030 SHALL verify: bgtz with A=0x8000_0000 -> not taken; with A=1 -> taken.
REQ-031 SHALL verify: jr with DA=10, fwd_wb=0x0000_0043 -> pc_if=0x40; j instr_id[25:0]=0x100 with pc4_id=0x1000_0004 -> pc_if=0x1000_0400.
REQ-032 SHALL verify: taken bne while stall_id=1 -> redirect=0 and all state held; on stall release -> redirect=1.
REQ-033 SHALL verify: rst_n pulsed low mid-FLUSH with imem_ready=0 -> pc_if=RESET_PC asynchronously, valid_id=0.
